// File: rtl/measure_pkg.sv
// Shared definitions for the measurement requester and the responder bench model.
package measure_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FREE = 3'd1,
    ST_OPEN      = 3'd2,
    ST_WINDOW    = 3'd3,
    ST_CLOSE     = 3'd4,
    ST_WAIT_RSP  = 3'd5
  } meas_state_e;

  // Smallest window that still leaves a low cycle between the two toggle pulses.
  localparam int unsigned MEAS_MIN_WINDOW  = 32'd2;
  localparam int unsigned MEAS_RSP_LATENCY = 32'd2;

endpackage

// File: rtl/measure_initiator_if.sv
// Requester/responder link: toggle request out, busy and result response back.
interface measure_initiator_if #(
  parameter int DATA_W = 16
);

  logic              measure_req_o;
  logic              busy_i;
  logic              result_rsp_i;
  logic [DATA_W-1:0] result_data_i;

  modport master (
    output measure_req_o,
    input  busy_i,
    input  result_rsp_i,
    input  result_data_i
  );

  modport slave (
    input  measure_req_o,
    output busy_i,
    output result_rsp_i,
    output result_data_i
  );

endinterface

// File: rtl/meas_timer.sv
// Loadable down-counter; tc flags the cycle in which the count reads one.
module meas_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] count_r;

  // Count register; saturates at zero so an idle timer never wraps into a terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == CNT_ONE);

endmodule

// File: rtl/measure_initiator.sv
// Requester for the one-shot measurement: opens a window on an idle responder,
// closes it after W cycles and collects the returned count or times out.
module measure_initiator
  import measure_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int WIN_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [WIN_W-1:0]    window_i,
  output logic                ready_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [DATA_W-1:0]   result_o,
  measure_initiator_if.master rsp_bus
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [WIN_W-1:0] WIN_MIN  = WIN_W'(MEAS_MIN_WINDOW);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1'b1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);

  function automatic logic [WIN_W-1:0] clamp_window(input logic [WIN_W-1:0] win);
    if (win < WIN_MIN) begin
      return WIN_MIN;
    end else begin
      return win;
    end
  endfunction

  meas_state_e       state_r;
  meas_state_e       state_next_s;
  logic [WIN_W-1:0]  win_r;
  logic [WIN_W-1:0]  win_load_val_s;
  logic              accept_s;
  logic              win_load_s;
  logic              win_dec_s;
  logic              win_tc_s;
  logic              tmo_load_s;
  logic              tmo_dec_s;
  logic              tmo_tc_s;
  logic              capture_s;
  logic              expire_s;
  logic              clear_s;
  logic              ready_r;
  logic              done_r;
  logic              timeout_r;
  logic              req_r;
  logic [DATA_W-1:0] result_r;

  // Window counter starts at W-1 so the CLOSE pulse lands exactly W cycles after OPEN.
  assign win_load_val_s = win_r - WIN_ONE;

  meas_timer #(.CNT_W(WIN_W)) u_win_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (win_load_s),
    .dec      (win_dec_s),
    .load_val (win_load_val_s),
    .tc       (win_tc_s)
  );

  meas_timer #(.CNT_W(TMO_W)) u_tmo_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmo_load_s),
    .dec      (tmo_dec_s),
    .load_val (TMO_LOAD),
    .tc       (tmo_tc_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and timer control; a response beats a simultaneous timeout.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    win_load_s   = 1'b0;
    win_dec_s    = 1'b0;
    tmo_load_s   = 1'b0;
    tmo_dec_s    = 1'b0;
    capture_s    = 1'b0;
    expire_s     = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          accept_s     = 1'b1;
          tmo_load_s   = 1'b1;
          state_next_s = ST_WAIT_FREE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_FREE: begin
        if (!rsp_bus.busy_i) begin
          state_next_s = ST_OPEN;
        end else if (tmo_tc_s) begin
          expire_s     = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          tmo_dec_s = 1'b1;
        end
      end
      ST_OPEN: begin
        win_load_s   = 1'b1;
        state_next_s = ST_WINDOW;
      end
      ST_WINDOW: begin
        if (win_tc_s) begin
          state_next_s = ST_CLOSE;
        end else begin
          win_dec_s = 1'b1;
        end
      end
      ST_CLOSE: begin
        tmo_load_s   = 1'b1;
        state_next_s = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (rsp_bus.result_rsp_i) begin
          capture_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else if (tmo_tc_s) begin
          expire_s     = 1'b1;
          clear_s      = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          tmo_dec_s = 1'b1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Window length latch, clamped so OPEN and CLOSE never merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r <= {WIN_W{1'b0}};
    end else if (accept_s) begin
      win_r <= clamp_window(window_i);
    end else begin
      win_r <= win_r;
    end
  end

  // Registered status and toggle pulses; ready rises together with done/timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      req_r     <= 1'b0;
    end else begin
      ready_r   <= (state_next_s == ST_IDLE);
      done_r    <= capture_s;
      timeout_r <= expire_s;
      req_r     <= (state_r == ST_OPEN) || (state_r == ST_CLOSE);
    end
  end

  // Result holder: a lost response reads back as zero, a busy-abort keeps the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= {DATA_W{1'b0}};
    end else if (capture_s) begin
      result_r <= rsp_bus.result_data_i;
    end else if (clear_s) begin
      result_r <= {DATA_W{1'b0}};
    end else begin
      result_r <= result_r;
    end
  end

  assign ready_o               = ready_r;
  assign done_o                = done_r;
  assign timeout_o             = timeout_r;
  assign result_o              = result_r;
  assign rsp_bus.measure_req_o = req_r;

endmodule

// File: tb/tb_measure_initiator.sv
// Self-checking bench for measure_initiator with a behavioural responder and timing model.
module tb_measure_initiator;
  import measure_pkg::*;

  localparam int DATA_W  = 16;
  localparam int WIN_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int LAT     = int'(MEAS_RSP_LATENCY);
  localparam int MIN_W   = int'(MEAS_MIN_WINDOW);

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              start_i  = 1'b0;
  logic [WIN_W-1:0]  window_i = '0;
  logic              ready_o;
  logic              done_o;
  logic              timeout_o;
  logic [DATA_W-1:0] result_o;

  measure_initiator_if #(.DATA_W(DATA_W)) rsp_bus ();

  measure_initiator #(
    .DATA_W  (DATA_W),
    .WIN_W   (WIN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .window_i  (window_i),
    .ready_o   (ready_o),
    .done_o    (done_o),
    .timeout_o (timeout_o),
    .result_o  (result_o),
    .rsp_bus   (rsp_bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_q[$];
  int done_q[$];
  int tmo_q[$];
  int low_ready      = 0;
  bit counting       = 1'b0;
  int busy_until     = 0;
  int rsp_at         = -1;
  int start_pulse_at = -1;
  int rsp_mode       = 0;
  logic [DATA_W-1:0] rsp_val      = '0;
  logic [DATA_W-1:0] model_result = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  // One clock: record outputs after the edge, then act as responder and host.
  // rsp_mode: 0 = answer LAT cycles after the closing toggle, 1 = never answer,
  // 2 = answer so the response is sampled on the timeout-expiry edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (rsp_bus.measure_req_o === 1'b1) begin
      req_q.push_back(cyc);
      counting = !counting;
      if (!counting) begin
        if (rsp_mode == 0) rsp_at = cyc + LAT;
        else if (rsp_mode == 2) rsp_at = cyc + TIMEOUT - 1;
      end
    end
    if (done_o === 1'b1) done_q.push_back(cyc);
    if (timeout_o === 1'b1) tmo_q.push_back(cyc);
    if (ready_o !== 1'b1) low_ready++;
    rsp_bus.busy_i        = (cyc < busy_until);
    rsp_bus.result_rsp_i  = (cyc == rsp_at);
    rsp_bus.result_data_i = (cyc == rsp_at) ? rsp_val : DATA_W'($urandom);
    start_i               = (cyc == start_pulse_at);
  endtask

  task automatic clear_obs();
    req_q.delete();
    done_q.delete();
    tmo_q.delete();
    low_ready      = 0;
    rsp_at         = -1;
    start_pulse_at = -1;
  endtask

  task automatic run(input int win, input int busy_len, input int mode, input int glitch,
                     input logic [DATA_W-1:0] val, output int k);
    int limit;
    clear_obs();
    rsp_mode       = mode;
    rsp_val        = val;
    window_i       = WIN_W'(win);
    start_i        = 1'b1;
    rsp_bus.busy_i = (busy_len > 0);
    busy_until     = cyc + 1 + busy_len;
    tick();
    k = cyc;
    window_i       = WIN_W'($urandom);
    start_pulse_at = (glitch > 0) ? k + glitch : -1;
    limit = busy_len + win + 3 * TIMEOUT;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_q.size() + tmo_q.size() > 0) break;
    end
    repeat (6) tick();
  endtask

  // Expected timeline from start edge k: open at k+busy+2, close W later,
  // done one cycle after the response is sampled, timeouts TIMEOUT after entry.
  task automatic expect_run(input string tag, input int k, input int win, input int busy_len,
                            input int mode, input logic [DATA_W-1:0] val);
    int w;
    int open_c;
    int close_c;
    int end_c;
    w = (win < MIN_W) ? MIN_W : win;
    if (busy_len >= TIMEOUT) begin
      end_c = k + TIMEOUT;
      check({tag, ".req_count"}, req_q.size(), 0);
      check({tag, ".timeout_at"}, q_at(tmo_q, 0), end_c);
      check({tag, ".done_count"}, done_q.size(), 0);
    end else begin
      open_c  = k + busy_len + 2;
      close_c = open_c + w;
      check({tag, ".req_count"}, req_q.size(), 2);
      check({tag, ".open_at"}, q_at(req_q, 0), open_c);
      check({tag, ".close_at"}, q_at(req_q, 1), close_c);
      if (mode == 1) begin
        end_c = close_c + TIMEOUT;
        check({tag, ".timeout_at"}, q_at(tmo_q, 0), end_c);
        check({tag, ".done_count"}, done_q.size(), 0);
        model_result = '0;
      end else begin
        end_c = (mode == 0) ? close_c + LAT + 1 : close_c + TIMEOUT;
        check({tag, ".done_at"}, q_at(done_q, 0), end_c);
        check({tag, ".done_count"}, done_q.size(), 1);
        check({tag, ".timeout_count"}, tmo_q.size(), 0);
        model_result = val;
      end
    end
    check({tag, ".result"}, result_o, model_result);
    check({tag, ".ready_end"}, ready_o, 1'b1);
    check({tag, ".busy_span"}, low_ready, end_c - k);
  endtask

  initial begin
    int k;
    int win;
    int bl;
    logic [DATA_W-1:0] v;

    rsp_bus.busy_i        = 1'b0;
    rsp_bus.result_rsp_i  = 1'b0;
    rsp_bus.result_data_i = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset.ready", ready_o, 1'b1);
    check("reset.done", done_o, 1'b0);
    check("reset.timeout", timeout_o, 1'b0);
    check("reset.req", rsp_bus.measure_req_o, 1'b0);
    check("reset.result", result_o, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    run(10, 0, 0, 0, 16'hBEEF, k);
    expect_run("normal", k, 10, 0, 0, 16'hBEEF);

    v = DATA_W'($urandom) | 16'h0001;
    run(0, 0, 0, 0, v, k);
    expect_run("min_w0", k, 0, 0, 0, v);
    v = DATA_W'($urandom) | 16'h0001;
    run(1, 0, 0, 0, v, k);
    expect_run("min_w1", k, 1, 0, 0, v);

    v = DATA_W'($urandom) | 16'h0001;
    run(10, 20, 0, 0, v, k);
    expect_run("busy20", k, 10, 20, 0, v);

    run(10, 100, 0, 0, 16'h1234, k);
    expect_run("busy100", k, 10, 100, 0, 16'h1234);

    run(8, 0, 1, 0, 16'h5A5A, k);
    expect_run("no_rsp", k, 8, 0, 1, 16'h5A5A);

    v = DATA_W'($urandom) | 16'h0001;
    run(8, 0, 2, 0, v, k);
    expect_run("rsp_at_expiry", k, 8, 0, 2, v);

    v = DATA_W'($urandom) | 16'h0001;
    run(10, 0, 0, 5, v, k);
    expect_run("start_in_window", k, 10, 0, 0, v);

    clear_obs();
    rsp_bus.result_rsp_i  = 1'b1;
    rsp_bus.result_data_i = ~model_result;
    tick();
    tick();
    check("spurious.result", result_o, model_result);
    check("spurious.done_count", done_q.size(), 0);

    clear_obs();
    rsp_mode   = 0;
    window_i   = WIN_W'(30);
    start_i    = 1'b1;
    busy_until = cyc + 1;
    tick();
    repeat (8) tick();
    check("rst_mid.open_seen", req_q.size(), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.req", rsp_bus.measure_req_o, 1'b0);
    check("rst_mid.ready", ready_o, 1'b1);
    check("rst_mid.result", result_o, 16'h0000);
    counting     = 1'b0;
    model_result = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("rst_mid.no_close", req_q.size(), 1);

    v = DATA_W'($urandom) | 16'h0001;
    run(12, 0, 0, 0, v, k);
    expect_run("after_reset", k, 12, 0, 0, v);

    for (int r = 0; r < 6; r++) begin
      win = int'($urandom_range(0, 40));
      bl  = int'($urandom_range(0, 10));
      v   = DATA_W'($urandom);
      run(win, bl, 0, 0, v, k);
      expect_run("random", k, win, bl, 0, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
